// File: rtl/dmem_dual_slot_sequencer.sv
// Sequences a dual-issue bundle onto one single-port synchronous-read memory,
// slot 0 first, and returns both slots' write-back results in one cycle.
//
// state | meaning
// IDLE  | waiting for a bundle; accepts and latches it when in_valid=1
// ISS0  | slot 0 memory access issued
// ISS1  | slot 1 memory access issued; slot 0 load data captured if any
// DRAIN | last-issued load data captured; no access
// OUT   | wb_valid pulse with both slots' results
module dmem_dual_slot_sequencer #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [31:0]       alu_res0,
   input  logic [31:0]       alu_res1,
   input  logic [31:0]       wdata0,
   input  logic [31:0]       wdata1,
   input  logic              mem_read0,
   input  logic              mem_read1,
   input  logic              mem_write0,
   input  logic              mem_write1,
   input  logic              reg_write0,
   input  logic              reg_write1,
   input  logic [4:0]        rd0,
   input  logic [4:0]        rd1,
   output logic              stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              wb_valid,
   output logic [31:0]       wb_data0,
   output logic [31:0]       wb_data1,
   output logic [4:0]        wb_rd0,
   output logic [4:0]        wb_rd1,
   output logic              wb_en0,
   output logic              wb_en1
);

   typedef enum logic [2:0] {IDLE, ISS0, ISS1, DRAIN, OUT} state_t;

   state_t      state_q, state_d;
   logic [31:0] res0_q, res1_q;
   logic [31:0] wdata0_q, wdata1_q;
   logic [4:0]  rd0_q, rd1_q;
   logic        rw0_q, rw1_q;
   logic        st0_q, st1_q;
   logic        ld0_q, ld1_q;

   // A store wins over a load when both flags are set on one slot.
   logic ld0_in, ld1_in, op0_in, op1_in, op1_q;
   assign ld0_in = mem_read0 & ~mem_write0;
   assign ld1_in = mem_read1 & ~mem_write1;
   assign op0_in = mem_read0 | mem_write0;
   assign op1_in = mem_read1 | mem_write1;
   assign op1_q  = st1_q | ld1_q;

   assign stall = in_valid & (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         res0_q   <= '0;
         res1_q   <= '0;
         wdata0_q <= '0;
         wdata1_q <= '0;
         rd0_q    <= '0;
         rd1_q    <= '0;
         rw0_q    <= 1'b0;
         rw1_q    <= 1'b0;
         st0_q    <= 1'b0;
         st1_q    <= 1'b0;
         ld0_q    <= 1'b0;
         ld1_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  res0_q   <= alu_res0;
                  res1_q   <= alu_res1;
                  wdata0_q <= wdata0;
                  wdata1_q <= wdata1;
                  rd0_q    <= rd0;
                  rd1_q    <= rd1;
                  rw0_q    <= reg_write0;
                  rw1_q    <= reg_write1;
                  st0_q    <= mem_write0;
                  st1_q    <= mem_write1;
                  ld0_q    <= ld0_in;
                  ld1_q    <= ld1_in;
               end
            end
            // A slot 0 load always routes through ISS0, so its data is here now.
            ISS1: begin
               if (ld0_q) res0_q <= mem_rdata;
            end
            DRAIN: begin
               if (op1_q) begin
                  if (ld1_q) res1_q <= mem_rdata;
               end else if (ld0_q) begin
                  res0_q <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      wb_valid  = 1'b0;
      wb_data0  = '0;
      wb_data1  = '0;
      wb_rd0    = '0;
      wb_rd1    = '0;
      wb_en0    = 1'b0;
      wb_en1    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (op0_in)      state_d = ISS0;
               else if (op1_in) state_d = ISS1;
               else             state_d = OUT;
            end
         end
         ISS0: begin
            mem_en    = 1'b1;
            mem_we    = st0_q;
            mem_addr  = res0_q[ADDR_W+1:2];
            mem_wdata = wdata0_q;
            state_d   = op1_q ? ISS1 : DRAIN;
         end
         ISS1: begin
            mem_en    = 1'b1;
            mem_we    = st1_q;
            mem_addr  = res1_q[ADDR_W+1:2];
            mem_wdata = wdata1_q;
            state_d   = DRAIN;
         end
         DRAIN: state_d = OUT;
         OUT: begin
            wb_valid = 1'b1;
            wb_data0 = res0_q;
            wb_data1 = res1_q;
            wb_rd0   = rd0_q;
            wb_rd1   = rd1_q;
            wb_en0   = rw0_q & (rd0_q != 5'd0);
            wb_en1   = rw1_q & (rd1_q != 5'd0);
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset must suppress any access or write-back in the same cycle.
      if (reset) begin
         state_d   = IDLE;
         mem_en    = 1'b0;
         mem_we    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
         wb_valid  = 1'b0;
         wb_data0  = '0;
         wb_data1  = '0;
         wb_rd0    = '0;
         wb_rd1    = '0;
         wb_en0    = 1'b0;
         wb_en1    = 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_dual_slot_sequencer.sv
// Directed bench for dmem_dual_slot_sequencer: vector table of bundles against a
// behavioural synchronous-read memory, plus back-to-back and mid-bundle reset sequences.
module tb_dmem_dual_slot_sequencer;

   localparam int ADDR_W = 10;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic [31:0]       alu_res0, alu_res1, wdata0, wdata1;
   logic              mem_read0, mem_read1, mem_write0, mem_write1;
   logic              reg_write0, reg_write1;
   logic [4:0]        rd0, rd1;
   logic              stall, mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata, mem_rdata;
   logic              wb_valid;
   logic [31:0]       wb_data0, wb_data1;
   logic [4:0]        wb_rd0, wb_rd1;
   logic              wb_en0, wb_en1;

   int n_chk  = 0;
   int n_fail = 0;

   dmem_dual_slot_sequencer #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .alu_res0(alu_res0), .alu_res1(alu_res1),
      .wdata0(wdata0), .wdata1(wdata1),
      .mem_read0(mem_read0), .mem_read1(mem_read1),
      .mem_write0(mem_write0), .mem_write1(mem_write1),
      .reg_write0(reg_write0), .reg_write1(reg_write1),
      .rd0(rd0), .rd1(rd1),
      .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_data0(wb_data0), .wb_data1(wb_data1),
      .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .wb_en0(wb_en0), .wb_en1(wb_en1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   typedef struct {
      string       name;
      logic [31:0] a0, a1, w0, w1;
      logic        r0, r1, wr0, wr1, rw0, rw1;
      logic [4:0]  rd0, rd1;
      int          lat, nmem;
      logic [9:0]  fa;
      logic        fwe;
      logic [31:0] d0, d1;
      logic        e0, e1;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mkv(string nm,
         logic [31:0] a0, logic [31:0] w0, logic r0, logic wr0, logic rw0, logic [4:0] rd0,
         logic [31:0] a1, logic [31:0] w1, logic r1, logic wr1, logic rw1, logic [4:0] rd1,
         int lat, int nmem, logic [9:0] fa, logic fwe,
         logic [31:0] d0, logic e0, logic [31:0] d1, logic e1);
      vec_t v;
      v.name = nm;
      v.a0 = a0; v.w0 = w0; v.r0 = r0; v.wr0 = wr0; v.rw0 = rw0; v.rd0 = rd0;
      v.a1 = a1; v.w1 = w1; v.r1 = r1; v.wr1 = wr1; v.rw1 = rw1; v.rd1 = rd1;
      v.lat = lat; v.nmem = nmem; v.fa = fa; v.fwe = fwe;
      v.d0 = d0; v.e0 = e0; v.d1 = d1; v.e1 = e1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      alu_res0 = v.a0; wdata0 = v.w0; mem_read0 = v.r0; mem_write0 = v.wr0;
      reg_write0 = v.rw0; rd0 = v.rd0;
      alu_res1 = v.a1; wdata1 = v.w1; mem_read1 = v.r1; mem_write1 = v.wr1;
      reg_write1 = v.rw1; rd1 = v.rd1;
   endtask

   task automatic apply(input vec_t v);
      int          lat  = -1;
      int          nmem = 0;
      logic [9:0]  fa   = '0;
      logic        fwe  = 1'b0;
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      chk({v.name, " stall_idle"}, stall, 0);
      @(posedge clk);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (mem_en) begin
            if (nmem == 0) begin
               fa  = mem_addr;
               fwe = mem_we;
            end
            nmem++;
         end
         if (wb_valid && lat < 0) begin
            lat = k;
            chk({v.name, " wb_data0"}, wb_data0, v.d0);
            chk({v.name, " wb_data1"}, wb_data1, v.d1);
            chk({v.name, " wb_rd0"}, wb_rd0, v.rd0);
            chk({v.name, " wb_rd1"}, wb_rd1, v.rd1);
            chk({v.name, " wb_en0"}, wb_en0, v.e0);
            chk({v.name, " wb_en1"}, wb_en1, v.e1);
         end
      end
      chk({v.name, " latency"}, lat, v.lat);
      chk({v.name, " mem_accesses"}, nmem, v.nmem);
      if (v.nmem > 0) begin
         chk({v.name, " first_addr"}, fa, v.fa);
         chk({v.name, " first_we"}, fwe, v.fwe);
      end
   endtask

   task automatic chk_outs_zero(input string nm);
      chk({nm, " outputs_zero"},
          {mem_en, mem_we, mem_addr, mem_wdata, wb_valid, wb_en0, wb_en1,
           wb_rd0, wb_rd1, wb_data0, wb_data1, stall}, 0);
   endtask

   initial begin
      vec_t bb, rs;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem_rdata = 32'h0;
      //             name     a0         w0           r0 wr0 rw0 rd0    a1         w1          r1 wr1 rw1 rd1  lat nm fa      fwe d0            e0 d1            e1
      vecs[0] = mkv("alu",   32'h11,    0,            0, 0,  1, 5'd5,  32'h22,    0,           0, 0,  1, 5'd0,  1, 0, 10'h0,  0, 32'h11,       1, 32'h22,       0);
      vecs[1] = mkv("st_ld", 32'h40,    32'hA5A5,     0, 1,  0, 5'd0,  32'h40,    0,           1, 0,  1, 5'd7,  4, 2, 10'h10, 1, 32'h40,       0, 32'hA5A5,     1);
      vecs[2] = mkv("st_one",32'h40,    32'h1,        0, 1,  0, 5'd0,  32'h33,    0,           0, 0,  1, 5'd3,  3, 1, 10'h10, 1, 32'h40,       0, 32'h33,       1);
      vecs[3] = mkv("ld_st", 32'h40,    0,            1, 0,  1, 5'd8,  32'h40,    32'h2,       0, 1,  0, 5'd0,  4, 2, 10'h10, 0, 32'h1,        1, 32'h40,       0);
      vecs[4] = mkv("ld1",   32'h5,     0,            0, 0,  1, 5'd1,  32'h40,    0,           1, 0,  1, 5'd9,  3, 1, 10'h10, 0, 32'h5,        1, 32'h2,        1);
      vecs[5] = mkv("st_st", 32'h80,    32'h3,        0, 1,  0, 5'd0,  32'h80,    32'h4,       0, 1,  0, 5'd0,  4, 2, 10'h20, 1, 32'h80,       0, 32'h80,       0);
      vecs[6] = mkv("ld_st2",32'h80,    0,            1, 0,  1, 5'd10, 32'h77,    0,           0, 0,  0, 5'd11, 3, 1, 10'h20, 0, 32'h4,        1, 32'h77,       0);
      vecs[7] = mkv("rw_prc",32'h100,   32'hBEEF,     1, 1,  1, 5'd12, 32'h100,   0,           1, 0,  1, 5'd13, 4, 2, 10'h40, 1, 32'h100,      1, 32'hBEEF,     1);
      vecs[8] = mkv("hiaddr",32'h1FFC,  32'h12345678, 0, 1,  0, 5'd0,  32'h0FFC,  0,           1, 0,  1, 5'd14, 4, 2, 10'h3FF,1, 32'h1FFC,     0, 32'h12345678, 1);

      reset = 1'b1;
      in_valid = 1'b0;
      drive(vecs[0]);
      @(negedge clk);
      @(negedge clk);
      chk_outs_zero("reset");
      reset = 1'b0;
      @(negedge clk);
      chk_outs_zero("post_reset");

      foreach (vecs[i]) apply(vecs[i]);

      // Back-to-back: one-mem bundle held valid gives a 4-cycle cadence.
      bb = mkv("b2b", 32'h80, 0, 1, 0, 1, 5'd10, 32'h9, 0, 0, 0, 1, 5'd2,
               3, 1, 10'h20, 0, 32'h4, 1, 32'h9, 1);
      @(negedge clk);
      drive(bb);
      in_valid = 1'b1;
      begin
         int nwb = 0;
         for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("b2b stall k%0d", k), stall, (k % 4) != 0);
            chk($sformatf("b2b wb_valid k%0d", k), wb_valid, (k % 4) == 3);
            if (wb_valid) begin
               nwb++;
               chk($sformatf("b2b wb_data0 k%0d", k), wb_data0, 32'h4);
            end
         end
         chk("b2b wb_count", nwb, 3);
      end
      @(negedge clk);
      in_valid = 1'b0;

      // Reset during ISS1 of a store/store bundle.
      rs = mkv("rst", 32'h200, 32'hAA, 0, 1, 0, 5'd0, 32'h204, 32'hBB, 0, 1, 0, 5'd0,
               4, 2, 10'h80, 1, 32'h200, 0, 32'h204, 0);
      @(negedge clk);
      drive(rs);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("rst iss0 mem_en", mem_en, 1);
      @(negedge clk);
      chk("rst iss1 mem_en", mem_en, 1);
      reset = 1'b1;
      #1;
      chk("rst gated mem_en", mem_en, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_outs_zero("rst after");
      begin
         int nwb = 0;
         int nmem = 0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wb_valid) nwb++;
            if (mem_en) nmem++;
         end
         chk("rst no_wb", nwb, 0);
         chk("rst no_access", nmem, 0);
      end
      chk("rst slot0 stored", mem[10'h80], 32'hAA);
      chk("rst slot1 dropped", mem[10'h81], 32'h0);
      apply(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
